spi_slave_rx: RTL and testbench

Receive-side SPI stage that consumes the serial stream (spi_clk, cs, mosi) produced by the team's SPI master and turns it into parallel bytes in the system clk domain. The block synchronises the SPI inputs, detects clock edges, shifts bits in MSB-first, and presents completed bytes on a valid/ready output port, buffered by an optional small FIFO. It sits directly downstream of the master, either on-chip in loopback or in a second FPGA on the Spartan 6 board.

---
 rtl/spi_slave_rx_if.sv | 9 +
 rtl/spi_slave_rx.sv | 221 ++++++++++++++++++++++
 tb/tb_spi_slave_rx.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_rx_if.sv
// Byte output port of spi_slave_rx: valid/ready handshake carrying one received byte.
interface spi_slave_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/spi_slave_rx.sv
// SPI (CPOL=0, MSB first) receive stage: synchronise, sample on spi_clk fall, emit bytes.
// Define SPI_RX_FIFO_EN for a FIFO_DEPTH-entry output FIFO; otherwise a single holding register.
module spi_slave_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_clk_i,
  input  logic                  cs_i,
  input  logic                  mosi_i,
  spi_slave_rx_if.master        rx,
  output logic                  frame_err_o,
  output logic                  overrun_o,
  output logic                  busy_o,
  output logic [3:0]            bit_count_o
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("spi_slave_rx: SYNC_STAGES must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("spi_slave_rx: FIFO_DEPTH must be a power of two >= 2");
  end

  // ---------------------------------------------------------------- sync
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   fall_sclk, cs_fall, cs_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '1;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign fall_sclk = sclk_prev_q & ~sclk_s;
  assign cs_fall   = cs_prev_q & ~cs_s;
  assign cs_rise   = ~cs_prev_q & cs_s;

  // The chain resets to cs=1, so a cs held low across reset would look like a
  // fresh falling edge. Only arm once the flushed chain has shown cs high.
  localparam int SW = $clog2(SYNC_STAGES + 1);
  logic [SW-1:0] settle_q;
  logic          settled, armed_q;

  assign settled = (settle_q == SW'(SYNC_STAGES));

  always_ff @(posedge clk) begin
    if (reset) begin
      settle_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      if (!settled) settle_q <= settle_q + SW'(1);
      if (settled && cs_s) armed_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- fsm
  typedef enum logic [1:0] {IDLE, SHIFT, PUSH, ABORT} state_e;

  state_e     state_q;
  logic [7:0] shift_q;
  logic [3:0] bc_q;
  logic [3:0] bc_inc;
  logic       busy_q, ferr_q;

  assign bc_inc = bc_q + 4'(fall_sclk);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bc_q    <= '0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          bc_q <= '0;
          if (cs_fall && armed_q) begin
            state_q <= SHIFT;
            busy_q  <= 1'b1;
          end
        end
        SHIFT: begin
          if (fall_sclk) begin
            shift_q <= {shift_q[6:0], mosi_s};
            bc_q    <= bc_inc;
          end
          // a sample landing with cs_rise counts first, so bc_inc decides
          if (bc_inc == 4'd8) begin
            state_q <= PUSH;
          end else if (cs_rise) begin
            busy_q <= 1'b0;
            if (bc_inc == 4'd0) begin
              state_q <= IDLE;
            end else begin
              state_q <= ABORT;
              ferr_q  <= 1'b1;
            end
          end
        end
        PUSH: begin
          bc_q <= '0;
          if (cs_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= SHIFT;
          end
        end
        ABORT: begin
          ferr_q  <= 1'b0;
          shift_q <= '0;
          bc_q    <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic push;
  assign push = (state_q == PUSH);

  // ---------------------------------------------------------------- buffer
  logic [7:0] data_q;
  logic       ovr_q;
  logic       pop;

`ifdef SPI_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q, rptr_d;
  logic        empty, full, push_ok;
  logic [7:0]  data_d;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop     = !empty && rx.rx_ready;
  assign push_ok = push && (!full || pop);
  assign rptr_d  = rptr_q + PW'(pop);

  // data_q mirrors the head entry; the new head is either the byte being
  // written this cycle (buffer empty after any pop) or the next stored entry.
  always_comb begin
    data_d = data_q;
    if (push_ok && rptr_d == wptr_q)
      data_d = shift_q;
    else if (pop && rptr_d != wptr_q)
      data_d = mem_q[rptr_d[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      data_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q[AW-1:0]] <= shift_q;
        wptr_q                <= wptr_q + PW'(1);
      end
      rptr_q <= rptr_d;
      data_q <= data_d;
      if (push && full && !pop) ovr_q <= 1'b1;
    end
  end

  assign rx.rx_valid = !empty;
`else
  logic valid_q, push_ok;

  assign pop     = valid_q && rx.rx_ready;
  assign push_ok = push && (!valid_q || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      if (push_ok) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (pop) begin
        valid_q <= 1'b0;
      end
      if (push && valid_q && !pop) ovr_q <= 1'b1;
    end
  end

  assign rx.rx_valid = valid_q;
`endif

  assign rx.rx_data  = data_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
  assign busy_o      = busy_q;
  assign bit_count_o = bc_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Scoreboard bench for spi_slave_rx: bytes queued when sent, compared when popped.
module tb_spi_slave_rx;
  localparam int SYNC = 2;
  localparam int HALF = 2;
`ifdef SPI_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spi_clk = 1'b0;
  logic       cs = 1'b0;
  logic       mosi = 1'b1;
  logic       frame_err, overrun, busy;
  logic [3:0] bit_count;

  spi_slave_rx_if rx();

  spi_slave_rx #(.SYNC_STAGES(SYNC), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .spi_clk_i  (spi_clk),
    .cs_i       (cs),
    .mosi_i     (mosi),
    .rx         (rx),
    .frame_err_o(frame_err),
    .overrun_o  (overrun),
    .busy_o     (busy),
    .bit_count_o(bit_count)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         vld_cyc = 0;
  int         fe_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // output monitor: sampled 1 time unit after each falling clk edge
  always begin
    @(negedge clk);
    #1;
    if (rx.rx_valid === 1'b1) vld_cyc++;
    if (frame_err === 1'b1) fe_cnt++;
    if (rx.rx_valid === 1'b1 && rx.rx_ready === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_byte", 32'(rx.rx_valid), 32'd0);
      else                   chk("rx_data", 32'(rx.rx_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cs(input logic v);
    cs = v;
    tick(4);
  endtask

  // mosi changes 1 clk after the rise, so it is stable well around the fall
  task automatic send_bit(input logic b);
    spi_clk = 1'b1;
    tick(1);
    mosi = b;
    tick(HALF - 1);
    spi_clk = 1'b0;
    tick(HALF);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic wait_push(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick(1);
      if (bit_count == 4'd8) seen = 1'b1;
    end
  endtask

  task automatic drain();
    rx.rx_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      tick(1);
    end
    tick(2);
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    chk("drain_valid", 32'(rx.rx_valid), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(SYNC + 4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         seen;
    int         fe0, v0;
    logic [7:0] b;

    // reset held mid-frame with spi_clk toggling, released with cs still low
    rx.rx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      spi_clk = ~spi_clk;
    end
    spi_clk = 1'b0;
    reset = 1'b0;
    tick(1);
    chk("rst_valid", 32'(rx.rx_valid), 32'd0);
    chk("rst_data", 32'(rx.rx_data), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bc", 32'(bit_count), 32'd0);
    send_byte(8'h77);
    tick(4);
    chk("stale_busy", 32'(busy), 32'd0);
    chk("stale_bc", 32'(bit_count), 32'd0);
    set_cs(1'b1);
    tick(4);

    // single byte 0xA5
    fe0 = fe_cnt;
    v0  = vld_cyc;
    exp_q.push_back(8'hA5);
    set_cs(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    tick(2);
    chk("mid_bc", 32'(bit_count), 32'd3);
    chk("mid_busy", 32'(busy), 32'd1);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    fork
      send_bit(1'b1);
      begin
        wait_push(seen);
        chk("push_seen", 32'(seen), 32'd1);
        tick(1);
        chk("valid_latency", 32'(rx.rx_valid), 32'd1);
      end
    join
    set_cs(1'b1);
    tick(6);
    chk("single_vld_cycles", 32'(vld_cyc - v0), 32'd1);
    chk("single_ferr", 32'(fe_cnt - fe0), 32'd0);
    drain();

    // back-to-back bytes in one frame, consumer stalled
    rx.rx_ready = 1'b0;
    exp_q.push_back(8'h3C);
    if (CAP >= 2) exp_q.push_back(8'hFF);
    if (CAP >= 3) exp_q.push_back(8'h00);
    set_cs(1'b0);
    send_byte(8'h3C); send_byte(8'hFF); send_byte(8'h00);
    set_cs(1'b1);
    tick(4);
    chk("b2b_valid", 32'(rx.rx_valid), 32'd1);
    chk("b2b_ovr", 32'(overrun), 32'(CAP < 3));
    drain();

    // overrun: five bytes into a stalled buffer
    do_reset();
    rx.rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) if (i <= CAP) exp_q.push_back(8'(i));
    set_cs(1'b0);
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    tick(4);
    chk("ovr_after4", 32'(overrun), 32'(CAP < 4));
    send_byte(8'h05);
    set_cs(1'b1);
    tick(4);
    chk("ovr_after5", 32'(overrun), 32'd1);
    drain();
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // aborted frame after 5 bits, then a clean 0x81
    do_reset();
    rx.rx_ready = 1'b1;
    fe0 = fe_cnt;
    set_cs(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    tick(2);
    chk("abort_bc_pre", 32'(bit_count), 32'd5);
    set_cs(1'b1);
    tick(3);
    chk("abort_ferr", 32'(fe_cnt - fe0), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_bc", 32'(bit_count), 32'd0);
    exp_q.push_back(8'h81);
    set_cs(1'b0);
    send_byte(8'h81);
    set_cs(1'b1);
    tick(4);
    drain();
    chk("abort_ferr_once", 32'(fe_cnt - fe0), 32'd1);

    // push and pop in the same cycle with the buffer full
    do_reset();
    rx.rx_ready = 1'b0;
    set_cs(1'b0);
    for (int k = 0; k < CAP; k++) begin
      b = 8'h10 + 8'(k);
      exp_q.push_back(b);
      send_byte(b);
    end
    exp_q.push_back(8'hC3);
    b = 8'hC3;
    for (int i = 7; i >= 1; i--) send_bit(b[i]);
    fork
      send_bit(b[0]);
      begin
        wait_push(seen);
        rx.rx_ready = 1'b1;
      end
    join
    chk("full_push_seen", 32'(seen), 32'd1);
    set_cs(1'b1);
    tick(4);
    chk("full_pp_ovr", 32'(overrun), 32'd0);
    drain();
    chk("full_pp_ovr_end", 32'(overrun), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
